add32_seq_arb: RTL and testbench

Shared-adder controller. Arbitrates between two requesters, each wanting a DATA_W-bit addition, and sequences one internal SLICE_W-bit add slice over DATA_W/SLICE_W cycles. A carry register links the passes. One result is returned per operation on a valid/ready response channel tagged with the requester ID. It replaces two parallel 32-bit adders wherever throughput allows a multi-cycle add.

---
 rtl/add32_seq_arb.sv | 170 +++++++++++++++++
 tb/tb_add32_seq_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add32_seq_arb.sv
// rtl/add32_seq_arb.sv - two-requester shared adder, one SLICE_W slice per cycle
// Optional carry-out/overflow response outputs: define ADD_CARRY_OUT_EN.
module add32_seq_arb #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
`ifdef ADD_CARRY_OUT_EN
    output logic              rsp_cout,
    output logic              rsp_ovf,
`endif
    output logic              busy
);

    localparam int PASSES = DATA_W / SLICE_W;
    localparam int IDX_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              id_q, id_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rr_q, rr_d;
`ifdef ADD_CARRY_OUT_EN
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
`endif

    logic              idle;
    logic              grant_any;
    logic              grant_id;
    logic              last_pass;
    logic [31:0]       slice_off;
    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;
    logic [DATA_W-1:0] slice_mask;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W:0]   slice_res;

    // Round-robin only matters on contention; a lone requester always wins.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? rr_q : req1_valid;
        req0_ready = rst_n & idle & grant_any & ~grant_id;
        req1_ready = rst_n & idle & grant_any & grant_id;
    end

    // Single SLICE_W-bit adder, steered by the pass index through shifts.
    always_comb begin
        slice_off  = 32'(idx_q) * 32'(SLICE_W);
        a_sh       = a_q >> slice_off;
        b_sh       = b_q >> slice_off;
        slice_a    = a_sh[SLICE_W-1:0];
        slice_b    = b_sh[SLICE_W-1:0];
        slice_res  = {1'b0, slice_a} + {1'b0, slice_b} + (SLICE_W+1)'(carry_q);
        slice_mask = DATA_W'({SLICE_W{1'b1}});
        last_pass  = (idx_q == IDX_W'(PASSES - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        id_d    = id_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
`ifdef ADD_CARRY_OUT_EN
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    rr_d    = ~grant_id;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = (sum_q & ~(slice_mask << slice_off))
                        | (DATA_W'(slice_res[SLICE_W-1:0]) << slice_off);
                carry_d = slice_res[SLICE_W];
                idx_d   = idx_q + IDX_W'(1);
                if (last_pass) begin
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_DONE;
`ifdef ADD_CARRY_OUT_EN
                    cout_d  = slice_res[SLICE_W];
                    ovf_d   = (a_q[DATA_W-1] == b_q[DATA_W-1])
                            & (slice_res[SLICE_W-1] != a_q[DATA_W-1]);
`endif
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            rr_q    <= 1'b0;
`ifdef ADD_CARRY_OUT_EN
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
`ifdef ADD_CARRY_OUT_EN
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef ADD_CARRY_OUT_EN
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add32_seq_arb.sv
// tb/tb_add32_seq_arb.sv - table vectors plus scoreboard bench for add32_seq_arb
module tb_add32_seq_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_sum;
    logic        busy;
`ifdef ADD_CARRY_OUT_EN
    logic        rsp_cout;
    logic        rsp_ovf;
`endif

    add32_seq_arb #(.DATA_W(32), .SLICE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
`ifdef ADD_CARRY_OUT_EN
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    exp_t        sb_q[$];
    logic        grants[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_sum = '0;
    logic        last_cout = 1'b0;
    logic        last_ovf = 1'b0;
    logic        prev_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        logic [32:0] s;
        s      = {1'b0, a} + {1'b0, b};
        m.id   = id;
        m.sum  = s[31:0];
        m.cout = s[32];
        m.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
        return m;
    endfunction

    // Push expectations at accept, pop at response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready && req1_ready) chk("one_grant", 32'(req1_ready), 32'(1'b0));
            if ((req0_ready || req1_ready) && prev_ready) chk("ready_pulse", 32'(prev_ready), 32'(1'b0));
            prev_ready = req0_ready | req1_ready;
            if (req0_ready && req0_valid) begin
                sb_q.push_back(model(1'b0, req0_a, req0_b));
                grants.push_back(1'b0);
            end
            if (req1_ready && req1_valid) begin
                sb_q.push_back(model(1'b1, req1_a, req1_b));
                grants.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_sum", rsp_sum, e.sum);
`ifdef ADD_CARRY_OUT_EN
                    chk("sb_cout", 32'(rsp_cout), 32'(e.cout));
                    chk("sb_ovf", 32'(rsp_ovf), 32'(e.ovf));
                    last_cout = rsp_cout;
                    last_ovf  = rsp_ovf;
`endif
                    last_sum = rsp_sum;
                end
            end
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b);
        int t;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        t = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t >= 20) chk("accept_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 20);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 50) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          seen;
        int          t;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'hFFFF_0000, 32'h0001_FFFF, 32'h0000_FFFF, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h8000_FFFF, 32'h8000_0001, 32'h0001_0000, 1'b1, 1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sum", rsp_sum, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table vectors, latency of PASSES cycles after accept
        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            chk("tbl_latency", 32'(lat), 32'd2);
            @(posedge clk); #1;
            chk("tbl_sum", last_sum, vecs[i].exp_sum);
`ifdef ADD_CARRY_OUT_EN
            chk("tbl_cout", 32'(last_cout), 32'(vecs[i].exp_cout));
            chk("tbl_ovf", 32'(last_ovf), 32'(vecs[i].exp_ovf));
`endif
        end
        drain();

        // Alternating grants from a fresh reset, both requesters always valid
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grants.delete();
        req0_a = 32'h0000_0001; req0_b = 32'h0000_0002;
        req1_a = 32'h0000_0010; req1_b = 32'h0000_0020;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        t = 0;
        while (grants.size() < 4 && t < 60) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("alt_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            chk("alt_g0", 32'(grants[0]), 32'd0);
            chk("alt_g1", 32'(grants[1]), 32'd1);
            chk("alt_g2", 32'(grants[2]), 32'd0);
            chk("alt_g3", 32'(grants[3]), 32'd1);
        end
        drain();

        // Backpressure in DONE with a competing request waiting
        rsp_ready = 1'b0;
        issue(1'b0, 32'hDEAD_BEEF, 32'h0101_0101);
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'd2);
        req1_a = 32'h0000_0100; req1_b = 32'h0000_0023;
        req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_sum", rsp_sum, 32'hDFAE_BFF0);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_noaccept", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_reaccept", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Reset while RUN discards the operation
        issue(1'b0, 32'h0000_0005, 32'h0000_0006);
        rst_n = 1'b0;
        #1;
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_valid", 32'(rsp_valid), 32'd0);
        chk("rr_sum", rsp_sum, 32'd0);
        chk("rr_id", 32'(rsp_id), 32'd0);
        chk("rr_ready", 32'({req0_ready, req1_ready}), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rr_no_rsp", 32'(seen), 32'd0);
        issue(1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F1);
        wait_rsp(lat);
        chk("rr_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        chk("rr_sum_after", last_sum, 32'h0000_0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
